trap_sequencer: RTL and testbench

Trap and return sequencer for the pipelined core. It sits directly downstream of the machine CSR register file: it consumes `mtvec`, `mepc` and `mie` together with the per-stage exception codes and the `mret` indication, and it drives the PC redirect and the pipeline flush/stall controls. It also synchronises the external interrupt line and converts it into a trap entry request.

---
 rtl/trap_sequencer.sv | 111 +++++++++++
 tb/tb_trap_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap/return sequencer: arbitrates exceptions, mret and the synchronised external
// interrupt, then redirects the PC and drains the pipeline for a fixed number of cycles.
module trap_sequencer #(
  parameter int TRAP_FLUSH_CYCLES = 2,
  parameter int IRQ_SYNC_STAGES   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clk_en,
  input  logic [3:0]  i_exception_code_f_d_ff,
  input  logic [3:0]  i_exception_code_e_m_ff,
  input  logic        i_mret_e,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  input  logic [31:0] i_mie,
  input  logic        i_ext_irq,
  output logic        o_pc_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush_f_d,
  output logic        o_flush_d_e,
  output logic        o_flush_e_m,
  output logic        o_irq_take,
  output logic        o_busy
);

  localparam logic [3:0] NO_E       = 4'hF;
  localparam logic [3:0] FLUSH_INIT = 4'(TRAP_FLUSH_CYCLES);

  typedef enum logic [1:0] {IDLE, TRAP, RET, DRAIN} state_t;

  state_t                     state;
  logic [3:0]                 cnt;
  logic                       trap_is_irq;
  logic [IRQ_SYNC_STAGES-1:0] sync_q;
  logic                       irq_sync;
  logic                       exc_e_m, exc_f_d, irq_req;

  // Free-running synchroniser: keeps sampling even while the clock enable is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '0;
    else       sync_q <= {sync_q[IRQ_SYNC_STAGES-2:0], i_ext_irq};
  end

  assign irq_sync = sync_q[IRQ_SYNC_STAGES-1];
  assign exc_e_m  = (i_exception_code_e_m_ff != NO_E);
  assign exc_f_d  = (i_exception_code_f_d_ff != NO_E);
  assign irq_req  = irq_sync & i_mie[11];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      trap_is_irq <= 1'b0;
    end else if (i_clk_en) begin
      case (state)
        IDLE: begin
          if (exc_e_m || exc_f_d) begin
            state       <= TRAP;
            trap_is_irq <= 1'b0;
          end else if (i_mret_e) begin
            state <= RET;
          end else if (irq_req) begin
            state       <= TRAP;
            trap_is_irq <= 1'b1;
          end
        end
        TRAP, RET: begin
          state       <= DRAIN;
          cnt         <= FLUSH_INIT;
          trap_is_irq <= 1'b0;
        end
        DRAIN: begin
          // Inputs here belong to squashed instructions and are ignored.
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_pc_redirect = 1'b0;
    o_redirect_pc = '0;
    o_flush_f_d   = 1'b0;
    o_flush_d_e   = 1'b0;
    o_flush_e_m   = 1'b0;
    o_irq_take    = 1'b0;
    o_busy        = (state != IDLE);
    case (state)
      TRAP: begin
        o_pc_redirect = 1'b1;
        o_redirect_pc = {i_mtvec[31:2], 2'b00};
        o_flush_f_d   = 1'b1;
        o_flush_d_e   = 1'b1;
        o_flush_e_m   = 1'b1;
        o_irq_take    = trap_is_irq;
      end
      RET: begin
        // mret itself retires, so the E/M register is kept.
        o_pc_redirect = 1'b1;
        o_redirect_pc = {i_mepc[31:1], 1'b0};
        o_flush_f_d   = 1'b1;
        o_flush_d_e   = 1'b1;
      end
      DRAIN:   o_flush_f_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed vector table, hand-written corner sequences,
// and randomized traffic against an event-timeline reference model.
module tb_trap_sequencer;

  localparam int FLUSH = 2;
  localparam int SYNC  = 2;
  localparam logic [3:0] NO_E = 4'hF;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_clk_en;
  logic [3:0]  i_exception_code_f_d_ff, i_exception_code_e_m_ff;
  logic        i_mret_e;
  logic [31:0] i_mtvec, i_mepc, i_mie;
  logic        i_ext_irq;
  logic        o_pc_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_flush_f_d, o_flush_d_e, o_flush_e_m, o_irq_take, o_busy;

  int errors = 0;
  int checks = 0;

  trap_sequencer #(.TRAP_FLUSH_CYCLES(FLUSH), .IRQ_SYNC_STAGES(SYNC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
    .i_exception_code_f_d_ff(i_exception_code_f_d_ff),
    .i_exception_code_e_m_ff(i_exception_code_e_m_ff),
    .i_mret_e(i_mret_e), .i_mtvec(i_mtvec), .i_mepc(i_mepc), .i_mie(i_mie),
    .i_ext_irq(i_ext_irq), .o_pc_redirect(o_pc_redirect), .o_redirect_pc(o_redirect_pc),
    .o_flush_f_d(o_flush_f_d), .o_flush_d_e(o_flush_d_e), .o_flush_e_m(o_flush_e_m),
    .o_irq_take(o_irq_take), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {o_pc_redirect, o_flush_f_d, o_flush_d_e, o_flush_e_m, o_irq_take, o_busy};
  endfunction

  task automatic clear_events();
    i_exception_code_e_m_ff = NO_E;
    i_exception_code_f_d_ff = NO_E;
    i_mret_e = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  // Count cycles with o_busy high, starting from the current (already busy) cycle.
  task automatic count_busy(output int n);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (!o_busy) break;
      n++;
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted event appends its whole future output timeline; an empty
  // timeline means idle. irq_sync is the external line as sampled SYNC edges ago.
  typedef struct { int kind; bit irq; } slot_t;   // kind: 1 trap, 2 ret, 3 drain
  slot_t mq[$];
  bit    hq[$];

  task automatic model_reset();
    mq.delete();
    hq.delete();
    for (int k = 0; k < SYNC; k++) hq.push_back(1'b0);
  endtask

  task automatic push_event(input int kind, input bit irq);
    slot_t s;
    s.kind = kind; s.irq = irq;
    mq.push_back(s);
    for (int k = 0; k < FLUSH; k++) begin
      s.kind = 3; s.irq = 1'b0;
      mq.push_back(s);
    end
  endtask

  // Called with the inputs that the next rising edge will sample.
  task automatic model_step();
    bit synced;
    synced = hq[0];
    if (i_clk_en) begin
      if (mq.size() != 0) void'(mq.pop_front());
      else if (i_exception_code_e_m_ff != NO_E || i_exception_code_f_d_ff != NO_E) push_event(1, 1'b0);
      else if (i_mret_e) push_event(2, 1'b0);
      else if (synced && i_mie[11]) push_event(1, 1'b1);
    end
    hq.push_back(i_ext_irq);
    void'(hq.pop_front());
  endtask

  task automatic model_check();
    int kind;
    bit irq;
    logic [5:0]  e;
    logic [31:0] pc;
    kind = (mq.size() == 0) ? 0 : mq[0].kind;
    irq  = (mq.size() == 0) ? 1'b0 : mq[0].irq;
    pc   = (kind == 1) ? {i_mtvec[31:2], 2'b00} : (kind == 2) ? {i_mepc[31:1], 1'b0} : 32'h0;
    e    = {kind == 1 || kind == 2, kind != 0, kind == 1 || kind == 2, kind == 1,
            kind == 1 && irq, kind != 0};
    chk("rand_ctl", 32'(outs()), 32'(e));
    chk("rand_pc", o_redirect_pc, pc);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  em, fd;
    logic        mret;
    logic [31:0] mtvec, mepc, exp_pc;
    logic        exp_fem;
  } vec_t;
  vec_t vt[6];

  initial begin
    int n;
    vt[0] = '{4'h5, NO_E, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_0100, 1'b1};
    vt[1] = '{NO_E, 4'h2, 1'b0, 32'h8000_1006, 32'h0, 32'h8000_1004, 1'b1};
    vt[2] = '{NO_E, NO_E, 1'b1, 32'h0000_0200, 32'h0000_0041, 32'h0000_0040, 1'b0};
    vt[3] = '{4'h5, 4'h2, 1'b1, 32'h0000_0103, 32'h0000_0041, 32'h0000_0100, 1'b1};
    vt[4] = '{NO_E, 4'h3, 1'b1, 32'hFFFF_FFFF, 32'h0000_0011, 32'hFFFF_FFFC, 1'b1};
    vt[5] = '{NO_E, NO_E, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};

    i_rst = 1'b1; i_clk_en = 1'b1; i_ext_irq = 1'b0;
    i_mtvec = 32'h0; i_mepc = 32'h0; i_mie = 32'h0;
    clear_events();
    #1;
    chk("reset_ctl", 32'(outs()), 32'h0);
    chk("reset_pc", o_redirect_pc, 32'h0);
    do_reset();

    foreach (vt[i]) begin
      @(negedge i_clk);
      i_exception_code_e_m_ff = vt[i].em;
      i_exception_code_f_d_ff = vt[i].fd;
      i_mret_e = vt[i].mret;
      i_mtvec = vt[i].mtvec;
      i_mepc  = vt[i].mepc;
      @(negedge i_clk);
      clear_events();
      chk($sformatf("vec%0d_pc", i), o_redirect_pc, vt[i].exp_pc);
      chk($sformatf("vec%0d_ctl", i), 32'({o_pc_redirect, o_flush_f_d, o_flush_d_e, o_flush_e_m, o_irq_take}),
          32'({4'b1110, 1'b0} | {3'b000, vt[i].exp_fem, 1'b0}));
      @(negedge i_clk);
      chk($sformatf("vec%0d_drain", i), 32'(outs()), 32'b010001);
      chk($sformatf("vec%0d_drain_pc", i), o_redirect_pc, 32'h0);
      count_busy(n);
      chk($sformatf("vec%0d_busy_len", i), n, 32'd2);
    end

    // Clock enable dropped for 4 cycles in the first DRAIN cycle.
    @(negedge i_clk);
    i_exception_code_e_m_ff = 4'h7; i_mtvec = 32'h0000_0400;
    @(negedge i_clk);
    clear_events();
    @(negedge i_clk);
    i_clk_en = 1'b0;
    i_mret_e = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk($sformatf("hold%0d", k), 32'(outs()), 32'b010001);
    end
    i_clk_en = 1'b1;
    i_mret_e = 1'b0;
    @(negedge i_clk);
    chk("hold_resume", 32'(outs()), 32'b010001);
    @(negedge i_clk);
    chk("hold_idle", 32'(outs()), 32'h0);

    // Asynchronous reset in the middle of DRAIN.
    @(negedge i_clk);
    i_exception_code_e_m_ff = 4'h5; i_mtvec = 32'h0000_0103;
    @(negedge i_clk);
    clear_events();
    @(negedge i_clk);
    #1 i_rst = 1'b1;
    #1;
    chk("rst_mid_drain_ctl", 32'(outs()), 32'h0);
    chk("rst_mid_drain_pc", o_redirect_pc, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_mret_e = 1'b1; i_mepc = 32'h0000_0041;
    @(negedge i_clk);
    clear_events();
    chk("post_rst_ret_pc", o_redirect_pc, 32'h0000_0040);
    chk("post_rst_ret_ctl", 32'(outs()), 32'b111001);
    count_busy(n);

    // External interrupt with MEIE set: take pulse on the third cycle.
    @(negedge i_clk);
    i_mie = 32'h0000_0800; i_mtvec = 32'h0000_0C01;
    i_ext_irq = 1'b1;
    @(negedge i_clk);
    chk("irq_c1", 32'(outs()), 32'h0);
    @(negedge i_clk);
    chk("irq_c2", 32'(outs()), 32'h0);
    @(negedge i_clk);
    i_ext_irq = 1'b0;
    chk("irq_take_ctl", 32'(outs()), 32'b111111);
    chk("irq_take_pc", o_redirect_pc, 32'h0000_0C00);
    count_busy(n);
    chk("irq_busy_len", n, 32'd3);
    for (int k = 0; k < 4; k++) @(negedge i_clk);

    // Same stimulus with MEIE clear: never trapped.
    i_mie = 32'h0;
    i_ext_irq = 1'b1;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge i_clk);
      if (o_busy || o_irq_take) n++;
    end
    chk("irq_masked_busy_cycles", n, 32'd0);
    i_ext_irq = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    for (int k = 0; k < 600; k++) begin
      @(negedge i_clk);
      model_check();
      i_clk_en = ($urandom_range(0, 9) < 8);
      i_exception_code_e_m_ff = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 14)) : NO_E;
      i_exception_code_f_d_ff = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 14)) : NO_E;
      i_mret_e  = ($urandom_range(0, 9) == 0);
      i_mtvec   = $urandom;
      i_mepc    = $urandom;
      i_mie     = {$urandom} & ~32'h800 | (($urandom_range(0, 2) != 0) ? 32'h800 : 32'h0);
      if ($urandom_range(0, 19) == 0) i_ext_irq = ~i_ext_irq;
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
